// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: ALU op codes, operand widths
// and the arbiter FSM state encoding.
package alu_pkg;

    localparam int WIDTH = 8;
    localparam int OPW   = 3;

    localparam logic [OPW-1:0] OP_ADD = 3'b000;
    localparam logic [OPW-1:0] OP_SUB = 3'b001;
    localparam logic [OPW-1:0] OP_AND = 3'b010;
    localparam logic [OPW-1:0] OP_OR  = 3'b011;
    localparam logic [OPW-1:0] OP_XOR = 3'b100;
    localparam logic [OPW-1:0] OP_EQ  = 3'b101;
    localparam logic [OPW-1:0] OP_GT  = 3'b110;
    localparam logic [OPW-1:0] OP_SHL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin picker. A lone request wins outright; when both
// request, the pointer selects the winner (0 -> requester 0, 1 -> requester 1).
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // One-hot grant, pointer only matters on contention
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Arbiter sharing one external combinational ALU between two requesters.
// Three-phase operation: IDLE (grant + operand capture), EXEC (ALU settles on
// the registered operands, outputs captured), RESP (result held to the winner
// until it is consumed). Build option ALU_SHARE_ARB_STATS_EN adds per-requester
// grant counters on outputs grant_cnt0 / grant_cnt1.
module alu_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [2*OPW-1:0]   req_op,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_zero,
    output logic               rsp_carry,
    output logic               busy,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [OPW-1:0]     alu_op,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_zero,
    input  logic               alu_carry
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]   grant_cnt0,
    output logic [CNT_W-1:0]   grant_cnt1
`endif
);

    import alu_pkg::*;

    arb_state_e       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic [1:0]       gnt;

    rr_arb2 u_rr_arb2 (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // Next-state, operand/result capture and handshake outputs
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        op_d      = op_q;
        res_d     = res_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        case (state_q)
            IDLE: begin
                req_ready = gnt;
                if (gnt != 2'b00) begin
                    owner_d = gnt[1];
                    opa_d   = gnt[1] ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                    opb_d   = gnt[1] ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                    op_d    = gnt[1] ? req_op[2*OPW-1:OPW]    : req_op[OPW-1:0];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_result;
                zero_d  = alu_zero;
                carry_d = alu_carry;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                // The other requester's rsp_ready is deliberately ignored
                if (rsp_ready[owner_q]) begin
                    ptr_d   = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, operand and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign alu_a      = opa_q;
    assign alu_b      = opb_q;
    assign alu_op     = op_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign rsp_carry  = carry_q;
    assign busy       = (state_q != IDLE);

`ifdef ALU_SHARE_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // A request handshake is exactly a raised req_ready bit; counters wrap
    always_comb begin
        cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, req_ready[0]};
        cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, req_ready[1]};
    end

    // Grant counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 8-bit ALU (ports A, B, op_code, result, zero_flag, carry_flag) between two requesters.
- Round-robin grant, valid/ready request handshake, registered result and flags returned to the winning requester only.
- Drives the ALU input ports from its own operand registers and captures the ALU outputs; the ALU stays a separate instance beside it.

Parameters:
- WIDTH, 8, operand/result width; matches the ALU.
- OPW, 3, op_code width.
- CNT_W, 16, width of the grant counters (optional feature only).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  request valid, bit i = requester i.
- req_ready  out  2  request accepted, at most one bit high.
- req_a  in  2*WIDTH  operand A; slice i for requester i.
- req_b  in  2*WIDTH  operand B; slice i.
- req_op  in  2*OPW  op code; slice i.
- rsp_valid  out  2  response valid for requester i.
- rsp_ready  in  2  requester i consumes the response.
- rsp_result  out  WIDTH  captured ALU result (shared bus).
- rsp_zero  out  1  captured zero_flag.
- rsp_carry  out  1  captured carry_flag.
- busy  out  1  high in EXEC or RESP.
- alu_a / alu_b  out  WIDTH  to ALU A / B.
- alu_op  out  OPW  to ALU op_code.
- alu_result  in  WIDTH  from ALU.
- alu_zero / alu_carry  in  1  from ALU flags.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; operand regs, rsp_result, rsp_zero and rsp_carry = 0.
  - rsp_valid=0, busy=0, rr pointer=0 (requester 0 preferred).
  - req_ready is combinational and therefore 0 outside IDLE.
- FSM states:
  - IDLE:
    - grant = requester with req_valid set; if both are set, grant goes to rr pointer.
    - req_ready[grant]=1 in the same cycle (combinational from state, req_valid and pointer).
    - On handshake, capture that requester's a/b/op into the operand regs; go to EXEC.
    - No valid requests: stay in IDLE.
  - EXEC:
    - alu_a/alu_b/alu_op already hold the captured operands (they are driven from the regs at all times).
    - At the end of the cycle, register alu_result/zero/carry into rsp_*; go to RESP.
  - RESP:
    - rsp_valid[grant]=1; rsp_* held stable.
    - On rsp_ready[grant]: clear rsp_valid, set rr pointer = ~grant, go to IDLE.
    - rsp_ready on the non-granted bit is ignored.
- Latency and throughput:
  - Handshake at edge T gives rsp_valid at T+2.
  - Minimum 3 cycles per operation; no overlap of operations.
- Fairness: when both requesters keep requesting, grants alternate 0,1,0,1; the loser holds req_valid and operands stable (standard valid/ready).
- Boundary conditions:
  - New requests during EXEC/RESP are not accepted (req_ready=0).
  - Requester withdrawing req_valid before its grant is legal.
  - rsp_ready held low: stay in RESP indefinitely with data stable.
  - rst_n asserted mid-operation: operation aborts; no response is produced after reset release.
- Arithmetic and flags: performed entirely by the ALU; the arbiter passes them through unmodified, no width extension.

Optional Feature:
- Macro ALU_SHARE_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (CNT_W each), reset to 0.
  - Counter i increments on each request handshake for requester i and wraps to 0 after all-ones.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - op_code localparams: ADD=000, SUB=001, AND=010, OR=011, XOR=100, EQ=101, GT=110, SHL=111.
  - FSM state encoding: IDLE, EXEC, RESP.
  - Widths WIDTH and OPW.
- One natural sub-module, rr_arb2: 2-input round-robin picker (req[1:0], pointer in, one-hot grant out), purely combinational.

Test Plan:
- Single request: req0 ADD A=10 B=5 → req_ready[0] pulse; rsp_valid[0] two cycles later; result=15, zero=0.
- Carry: req1 ADD A=200 B=100 → rsp_valid[1]; result=44, carry=1.
- Zero: req0 SUB A=7 B=7 → result=0, zero=1.
- Contention: both valid every cycle (req0 AND 5,3; req1 OR 5,3), rsp_ready=1 → grants alternate 0,1,0,1; results 1, 7, 1, 7 on the matching rsp_valid bit.
- Backpressure: req0 XOR 5,3 with rsp_ready[0]=0 for 5 cycles → rsp_valid[0] stays high with result=6; req_ready=00 throughout; completes on the first rsp_ready[0]=1.
- Reset mid-operation: assert rst_n=0 during EXEC → all outputs 0 immediately; after release with no requests, rsp_valid stays 00. With ALU_SHARE_ARB_STATS_EN, counters read 0.
